// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter.
// onehot2idx covers up to 32 requesters; callers narrow the result to their index width.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [4:0] onehot2idx(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after ptr wins,
// wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] low_mask;
    logic [2*N-1:0] masked;
    logic           found;

    // The upper copy of req supplies the wrapped-around candidates below ptr.
    assign dbl      = {req, req};
    assign low_mask = ((2*N)'(1) << ptr) - (2*N)'(1);
    assign masked   = dbl & ~low_mask;
    assign any      = |req;

    always_comb begin
        gnt_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (masked[i] && !found) begin
                found             = 1'b1;
                gnt_onehot[i % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin sharing of one uart_tx between N requesters,
// with an optional watchdog that releases an owner that stops sending.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_valid,
    input  logic [N*DATA_W-1:0]   req_data,
    input  logic [N-1:0]          req_last,
    output logic [N-1:0]          req_ready,
    output logic                  tx_valid,
    output logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_ready,
    output logic [N-1:0]          grant,
    output logic                  busy
);

    localparam int PW = $clog2(N);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0] WD_MAX  = '1;

    arb_state_t        state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] data_arr [N];
    logic [PW-1:0]     own_idx;
    logic              own_valid;
    logic              own_last;
    logic              beat;
    logic              timed_out;
    logic              release_now;
    logic [N-1:0]      pick_gnt;
    logic              pick_any;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(.N(N)) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (pick_gnt),
        .any        (pick_any)
    );

    assign own_idx   = PW'(onehot2idx(32'(grant_q)));
    assign own_valid = req_valid[own_idx];
    assign own_last  = req_last[own_idx];

    // Datapath is a pure mux of the registered owner, so a byte never leaves without one.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == OWN) begin
            tx_valid           = own_valid;
            tx_data            = data_arr[own_idx];
            req_ready[own_idx] = tx_ready;
        end
    end

    assign beat        = tx_valid & tx_ready;
    assign timed_out   = (TIMEOUT > 0) && (state_q == OWN) && !beat && (wd_q == WD_LAST);
    assign release_now = (state_q == OWN) && ((beat && own_last) || timed_out);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    grant_d = pick_gnt;
                    wd_d    = '0;
                end
            end
            OWN: begin
                if (beat) begin
                    wd_d = '0;
                end else if (!own_valid && (wd_q != WD_MAX)) begin
                    wd_d = wd_q + 1'b1;
                end
                // Timeout only fires without a beat, so a release advances ptr once.
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (own_idx == PW'(N-1)) ? '0 : own_idx + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
